// File: rtl/pcm_cond_pkg.sv
// rtl/pcm_cond_pkg.sv - shared widths, output sample type and saturation helper
package pcm_cond_pkg;

   localparam int PCM_IN_W  = 32;
   localparam int PCM_OUT_W = 16;
   localparam int ACC_W     = PCM_IN_W + 2;

   typedef logic signed [PCM_OUT_W-1:0] pcm_out_t;

   // Clamp into the signed range of `width` bits; width must stay below 64.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// rtl/pcm_sync_fifo.sv - first-word-fall-through sync FIFO with exact level and drop flag
module pcm_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [W-1:0]             i_wr_data,
   output logic                     o_drop,
   output logic [W-1:0]             o_rd_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_level;
   logic [W-1:0]  r_last;
   logic          w_full;
   logic          w_rd;
   logic          w_wr;

   assign w_full    = (r_level == FULL_LVL);
   assign o_valid   = (r_level != '0);
   assign w_rd      = o_valid & i_ready;
   // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign w_wr      = i_wr_en & (~w_full | w_rd);
   assign o_drop    = i_wr_en & w_full & ~w_rd;
   assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : r_last;
   assign o_level   = r_level;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_last   <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/pcm_conditioner.sv
// rtl/pcm_conditioner.sv - DC removal, gain shift and saturation into an output FIFO
// Optional DC-removal filter enabled by defining PCM_COND_DC_EN.
module pcm_conditioner
   import pcm_cond_pkg::*;
#(
   parameter int IN_W       = PCM_IN_W,
   parameter int OUT_W      = PCM_OUT_W,
   parameter int DC_K       = 10,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [IN_W-1:0]               in_data,
   input  logic                          in_valid,
   input  logic [4:0]                    gain_shift,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic                          sat_event
);

   localparam int AW = IN_W + (ACC_W - PCM_IN_W);
   localparam int DW = IN_W + 1;

   logic                   r_s1_valid;
   logic signed [DW-1:0]   r_s1_d;
   logic                   r_s2_valid;
   logic                   r_s2_sat;
   logic signed [AW-1:0]   r_s2_y;
   logic                   r_s3_valid;
   logic                   r_s3_sat;
   logic signed [OUT_W-1:0] r_s3_s;
   logic                   r_ovf;

   logic signed [DW-1:0]   w_d;
   logic signed [AW-1:0]   w_y;
   logic                   w_y_sat;
   logic signed [63:0]     w_y_ext;
   logic signed [63:0]     w_shift64;
   logic signed [63:0]     w_s64;
   logic signed [OUT_W-1:0] w_s;
   logic                   w_s_sat;
   logic                   w_drop;

`ifdef PCM_COND_DC_EN
   logic signed [IN_W-1:0] r_x_prev;
   logic signed [AW-1:0]   r_y_prev;
   logic signed [AW-1:0]   w_leak;
   logic signed [63:0]     w_sum64;
   logic signed [63:0]     w_y64;

   always_comb begin
      w_d     = {in_data[IN_W-1], in_data} - {r_x_prev[IN_W-1], r_x_prev};
      w_leak  = r_y_prev >>> DC_K;
      w_sum64 = {{(64-DW){r_s1_d[DW-1]}}, r_s1_d}
              + {{(64-AW){r_y_prev[AW-1]}}, r_y_prev}
              - {{(64-AW){w_leak[AW-1]}}, w_leak};
      w_y64   = sat_to(w_sum64, AW);
      w_y     = w_y64[AW-1:0];
      w_y_sat = (w_y64 != w_sum64);
   end

   // Filter state tracks every valid sample, even ones later dropped at the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_prev <= '0;
         r_y_prev <= '0;
      end else begin
         if (in_valid)   r_x_prev <= in_data;
         if (r_s1_valid) r_y_prev <= w_y;
      end
   end
`else
   always_comb begin
      w_d     = {in_data[IN_W-1], in_data};
      w_y     = {{(AW-DW){r_s1_d[DW-1]}}, r_s1_d};
      w_y_sat = 1'b0;
   end
`endif

   always_comb begin
      w_y_ext   = {{(64-AW){r_s2_y[AW-1]}}, r_s2_y};
      w_shift64 = w_y_ext >>> gain_shift;
      w_s64     = sat_to(w_shift64, OUT_W);
      w_s       = w_s64[OUT_W-1:0];
      w_s_sat   = (w_s64 != w_shift64);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_d     <= '0;
         r_s2_valid <= 1'b0;
         r_s2_sat   <= 1'b0;
         r_s2_y     <= '0;
         r_s3_valid <= 1'b0;
         r_s3_sat   <= 1'b0;
         r_s3_s     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) r_s1_d <= w_d;
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_y   <= w_y;
            r_s2_sat <= w_y_sat;
         end
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_s3_s   <= w_s;
            r_s3_sat <= r_s2_sat | w_s_sat;
         end
         if (w_drop)              r_ovf <= 1'b1;
         else if (clear_overflow) r_ovf <= 1'b0;
      end
   end

   assign sat_event = r_s3_valid & r_s3_sat;
   assign overflow  = r_ovf;

   pcm_sync_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (r_s3_valid),
      .i_wr_data (r_s3_s),
      .o_drop    (w_drop),
      .o_rd_data (out_data),
      .o_valid   (out_valid),
      .i_ready   (out_ready),
      .o_level   (fifo_level)
   );

endmodule
